// File: rtl/gage_cipher_pkg.sv
// Shared definitions for the gage/ingage cipher cores: state encoding, default sizes
// and the XOR inverse transform used by the decipher datapath.
package gage_cipher_pkg;

    localparam int GAGE_BLOCK_SIZE = 64;
    localparam int GAGE_KEY_SIZE   = 64;
    localparam int GAGE_CNT_W      = 8;
    // Transform operates on a wide container so any BLOCK_SIZE up to this fits.
    localparam int GAGE_MAX_W      = 1024;

    typedef enum logic {
        IDLE       = 1'b0,
        PROCESSING = 1'b1
    } gage_state_e;

    function automatic logic [GAGE_MAX_W-1:0] inv_transform(
        input logic [GAGE_MAX_W-1:0] block,
        input logic [GAGE_MAX_W-1:0] key
    );
        return block ^ key ^ {GAGE_MAX_W{1'b1}};
    endfunction

endpackage

// File: rtl/gage_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping.
module gage_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/gage_ingage_decipher.sv
// Receive-side decipher core: fixed-latency recovery of plaintext from one ciphertext block.
// Optional keyed variant selected by defining DECIPHER_KEY_WHITEN_EN.
module gage_ingage_decipher
    import gage_cipher_pkg::*;
#(
    parameter int BLOCK_SIZE = GAGE_BLOCK_SIZE,
    parameter int KEY_SIZE   = GAGE_KEY_SIZE,
    parameter int LATENCY    = 2,
    parameter int DROP_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [KEY_SIZE-1:0]   key,
    input  logic [BLOCK_SIZE-1:0] ciphertext,
    output logic                  ready,
    output logic [BLOCK_SIZE-1:0] plaintext,
    output logic                  done,
    output logic                  busy,
    output logic [DROP_W-1:0]     drop_cnt
);

    // Handshake: a block is accepted on any rising edge where start=1 and ready=1;
    // done pulses for one cycle when plaintext updates; starts seen while busy are dropped
    // and counted, never queued.

    if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
        $error("gage_ingage_decipher: LATENCY must be in 1..255");
    end

    gage_state_e             state, next_state;
    logic [GAGE_CNT_W-1:0]   cnt;
    logic [BLOCK_SIZE-1:0]   ct_reg;
    logic [KEY_SIZE-1:0]     key_reg;
    logic [BLOCK_SIZE-1:0]   key_mask;
    logic                    accept, finish, drop;
    logic                    unused_key;

`ifdef DECIPHER_KEY_WHITEN_EN
    if (KEY_SIZE < BLOCK_SIZE) begin : g_bad_key
        $error("gage_ingage_decipher: KEY_SIZE must be >= BLOCK_SIZE for key whitening");
    end
    assign key_mask = key_reg[BLOCK_SIZE-1:0];
`else
    assign key_mask = '0;
`endif

    // Key bits outside the mask (or the whole key in the unkeyed build) are intentionally idle.
    assign unused_key = ^key_reg;

    assign ready = (state == IDLE);
    assign busy  = (state == PROCESSING);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        finish     = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = PROCESSING;
                end
            end
            PROCESSING: begin
                drop = start;
                if (cnt == '0) begin
                    finish     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            ct_reg    <= '0;
            key_reg   <= '0;
            plaintext <= '0;
            done      <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                ct_reg  <= ciphertext;
                key_reg <= key;
                cnt     <= GAGE_CNT_W'(LATENCY - 1);
            end else if (busy && (cnt != '0)) begin
                cnt <= cnt - GAGE_CNT_W'(1);
            end
            if (finish) begin
                plaintext <= BLOCK_SIZE'(inv_transform(GAGE_MAX_W'(ct_reg), GAGE_MAX_W'(key_mask)));
            end
        end
    end

    gage_sat_counter #(.W(DROP_W)) u_drop_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (drop),
        .count (drop_cnt)
    );

endmodule

// File: tb/tb_gage_ingage_decipher.sv
// Directed bench for gage_ingage_decipher: default instance plus a DROP_W=2, LATENCY=6
// instance for counter saturation. Define DECIPHER_KEY_WHITEN_EN for the keyed build.
module tb_gage_ingage_decipher;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] key;
    logic [63:0] ciphertext;
    logic        ready, done, busy;
    logic [63:0] plaintext;
    logic [7:0]  drop_cnt;

    logic        start_s;
    logic [63:0] key_s, ciphertext_s;
    logic        ready_s, done_s, busy_s;
    logic [63:0] plaintext_s;
    logic [1:0]  drop_cnt_s;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    gage_ingage_decipher u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key        (key),
        .ciphertext (ciphertext),
        .ready      (ready),
        .plaintext  (plaintext),
        .done       (done),
        .busy       (busy),
        .drop_cnt   (drop_cnt)
    );

    gage_ingage_decipher #(.LATENCY(6), .DROP_W(2)) u_sat (
        .clk        (clk),
        .reset      (reset),
        .start      (start_s),
        .key        (key_s),
        .ciphertext (ciphertext_s),
        .ready      (ready_s),
        .plaintext  (plaintext_s),
        .done       (done_s),
        .busy       (busy_s),
        .drop_cnt   (drop_cnt_s)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_done_sb(input string tag);
        logic [63:0] e;
        check({tag, "_done"}, 64'(done), 64'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_pt"}, plaintext, e);
        end
    endtask

    initial begin
        logic        seen_done;
        logic [63:0] exp_key_pt;

        reset = 1'b1;
        start = 1'b0;
        key = '0;
        ciphertext = '0;
        start_s = 1'b0;
        key_s = '0;
        ciphertext_s = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset then idle
        repeat (10) step();
        check("idle_ready", 64'(ready), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_done", 64'(done), 64'd0);
        check("idle_pt", plaintext, 64'd0);
        check("idle_drop", 64'(drop_cnt), 64'd0);

        // Single operation
        start = 1'b1;
        ciphertext = 64'hFFFF_FFFF_0000_0000;
        step();
        check("single_e0_busy", 64'(busy), 64'd1);
        check("single_e0_ready", 64'(ready), 64'd0);
        check("single_e0_done", 64'(done), 64'd0);
        start = 1'b0;
        ciphertext = 64'h1234_5678_9ABC_DEF0;
        step();
        check("single_e1_done", 64'(done), 64'd0);
        step();
        check("single_e2_done", 64'(done), 64'd1);
        check("single_e2_pt", plaintext, 64'h0000_0000_FFFF_FFFF);
        check("single_e2_ready", 64'(ready), 64'd1);
        step();
        check("single_e3_done", 64'(done), 64'd0);
        check("single_e3_pt", plaintext, 64'h0000_0000_FFFF_FFFF);

        // Back-to-back with start held high
        start = 1'b1;
        ciphertext = 64'h0;
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        exp_q.push_back(64'h0);
        step();
        ciphertext = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        check("b2b_e1_done", 64'(done), 64'd0);
        step();
        check_done_sb("b2b_first");
        step();
        check("b2b_e3_done", 64'(done), 64'd0);
        check("b2b_e3_busy", 64'(busy), 64'd1);
        step();
        check("b2b_e4_done", 64'(done), 64'd0);
        step();
        check_done_sb("b2b_second");
        start = 1'b0;
        check("b2b_drop", 64'(drop_cnt), 64'd4);
        step();
        check("b2b_after_done", 64'(done), 64'd0);

        // Asynchronous reset mid-cycle clears everything without a clock edge
        #2;
        reset = 1'b1;
        #1;
        check("async_pt", plaintext, 64'd0);
        check("async_drop", 64'(drop_cnt), 64'd0);
        check("async_ready", 64'(ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;

        // Drops while busy, operands unaffected
        step();
        start = 1'b1;
        ciphertext = 64'hA5A5_0F0F_3C3C_9696;
        step();
        ciphertext = 64'h0;
        step();
        check("drop_e1_cnt", 64'(drop_cnt), 64'd1);
        step();
        start = 1'b0;
        check("drop_e2_done", 64'(done), 64'd1);
        check("drop_e2_pt", plaintext, 64'h5A5A_F0F0_C3C3_6969);
        check("drop_e2_cnt", 64'(drop_cnt), 64'd2);
        step();
        check("drop_e3_cnt", 64'(drop_cnt), 64'd2);

        // Reset one cycle after accept abandons the operation
        start = 1'b1;
        ciphertext = 64'h0F0F_0F0F_0F0F_0F0F;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check("rst_mid_ready", 64'(ready), 64'd1);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_pt", plaintext, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mid_ready_after", 64'(ready), 64'd1);
        seen_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            seen_done = seen_done | done;
        end
        check("rst_mid_no_done", 64'(seen_done), 64'd0);
        check("rst_mid_pt_hold", plaintext, 64'd0);

        // Key handling: keyed build whitens, unkeyed build ignores the key
`ifdef DECIPHER_KEY_WHITEN_EN
        exp_key_pt = 64'hFEDC_BA98_7654_3210;
`else
        exp_key_pt = 64'hFFFF_FFFF_FFFF_FFFF;
`endif
        start = 1'b1;
        key = 64'h0123_4567_89AB_CDEF;
        ciphertext = 64'h0;
        step();
        start = 1'b0;
        key = 64'hFFFF_0000_FFFF_0000;
        step();
        step();
        check("key_done", 64'(done), 64'd1);
        check("key_pt", plaintext, exp_key_pt);

        // Saturation on the DROP_W=2, LATENCY=6 instance: five dropped starts
        start_s = 1'b1;
        ciphertext_s = 64'h5555_5555_5555_5555;
        step();
        check("sat_e0_busy", 64'(busy_s), 64'd1);
        step();
        step();
        step();
        check("sat_e3_cnt", 64'(drop_cnt_s), 64'd3);
        step();
        step();
        start_s = 1'b0;
        check("sat_e5_cnt", 64'(drop_cnt_s), 64'd3);
        check("sat_e5_done", 64'(done_s), 64'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 3 && !seen_done; i++) begin
            step();
            seen_done = done_s;
        end
        check("sat_done_seen", 64'(seen_done), 64'd1);
        check("sat_pt", plaintext_s, 64'hAAAA_AAAA_AAAA_AAAA);
        check("sat_final_cnt", 64'(drop_cnt_s), 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gage_ingage_decipher.md
Name: gage_ingage_decipher

Overview:
Inverse of the team's gage/ingage block cipher. It accepts one ciphertext block on a start strobe and runs a fixed-latency processing phase. It then returns the recovered plaintext (ciphertext XOR all-ones) with a one-cycle done pulse. It sits on the receive side of the crypto datapath, paired with the encrypt core, and uses the same start/done protocol. It adds a ready indication and a drop counter for starts that arrive while it is busy.

Parameters:
BLOCK_SIZE, 64, width of ciphertext/plaintext block.
KEY_SIZE, 64, key width; must be >= BLOCK_SIZE when DECIPHER_KEY_WHITEN_EN is defined.
LATENCY, 2, processing cycles from accept edge to done; legal range 1..255.
DROP_W, 8, width of saturating dropped-start counter.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request; sampled each rising edge.
key  input  KEY_SIZE  key; captured with ciphertext on accept.
ciphertext  input  BLOCK_SIZE  block to decrypt; captured on accept.
ready  output  1  high when the block can accept start (state IDLE).
plaintext  output  BLOCK_SIZE  result register; holds value until the next completion.
done  output  1  one-cycle pulse when plaintext updates.
busy  output  1  high while in PROCESSING.
drop_cnt  output  DROP_W  count of starts ignored while busy; saturates at all-ones.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, plaintext=0, done=0, drop_cnt=0, internal ct/key/count regs=0. An in-flight operation is abandoned; no done is generated for it.
- ready = (state==IDLE); busy = (state==PROCESSING). Both decoded from the state register, no combinational path from start.
- IDLE: done<=0 (except the completion pulse described below). If start=1, capture ciphertext and key, load cnt<=LATENCY-1, go to PROCESSING. This edge is the accept edge E0.
- PROCESSING, cnt!=0: cnt<=cnt-1.
- PROCESSING, cnt==0: plaintext<=ct_reg ^ {BLOCK_SIZE{1'b1}}; done<=1; state<=IDLE.
- Latency: done is high in the cycle following edge E0+LATENCY. With LATENCY=2 and start high before edge 0, done is high between edges 2 and 3.
- done is exactly one cycle. In the cycle after the completion edge, state is IDLE and ready=1.
- Start with done high: state is IDLE, so the start is accepted. Back-to-back throughput is one block per LATENCY+1 cycles.
- Start while PROCESSING: ignored. Captured operands are unchanged. drop_cnt increments by 1, saturating at 2^DROP_W-1. This includes the completion cycle (cnt==0).
- Inputs are sampled only at the accept edge. Changes to ciphertext/key during PROCESSING have no effect.
- plaintext is stable between completions and is never cleared except by reset.

Optional Feature:
Macro DECIPHER_KEY_WHITEN_EN.
- Defined: the result is ct_reg ^ key_reg[BLOCK_SIZE-1:0] ^ all-ones, matching the keyed encrypt variant. Elaboration fails (generate-time check) if KEY_SIZE < BLOCK_SIZE.
- Not defined: the key is captured but unused; the result is ct_reg ^ all-ones. Timing and handshake are identical in both builds.

Decomposition:
- Shared package gage_cipher_pkg holds:
  - the state enum (IDLE, PROCESSING), shared with the encrypt core;
  - the default BLOCK_SIZE/KEY_SIZE localparams;
  - the function inv_transform(block, key) implementing the XOR rule, used by both RTL and bench model.
- One sub-module is natural: gage_sat_counter (DROP_W-bit saturating incrementer with enable), reused for the encrypt-side statistics later.

Test Plan:
- Reset then idle: hold start=0 for 10 cycles -> ready=1, busy=0, done=0, plaintext=0, drop_cnt=0.
- Single op, LATENCY=2: ciphertext=64'hFFFF_FFFF_0000_0000, start pulse before edge 0 -> done high only between edges 2-3, plaintext=64'h0000_0000_FFFF_FFFF.
- Back-to-back: start held high with ciphertext 64'h0 then 64'hFFFF_FFFF_FFFF_FFFF -> plaintexts 64'hFFFF_FFFF_FFFF_FFFF then 64'h0, done pulses 3 cycles apart.
- Drop: start accepted, then start held high 2 more cycles while busy -> drop_cnt=2; the original result is unaffected. With DROP_W=2 and 5 dropped starts -> drop_cnt=3 (saturated).
- Reset mid-op: assert reset one cycle after accept -> no done pulse, plaintext=0, ready=1 immediately after reset deassertion.
- DECIPHER_KEY_WHITEN_EN build: key=64'h0123_4567_89AB_CDEF, ciphertext=64'h0 -> plaintext=64'hFEDC_BA98_7654_3210.
